// File: rtl/sobel_pkg.sv
// Shared definitions for the image front end: channel width default, streamer
// FSM encoding, packed-pixel field extraction and luma weights.
package sobel_pkg;

  localparam int CH_BITS_DEF = 4;
  localparam int MAX_CH      = 16;

  // Luma approximation: (R + 2G + B) >> 2
  localparam int GRAY_WR    = 1;
  localparam int GRAY_WG    = 2;
  localparam int GRAY_WB    = 1;
  localparam int GRAY_SHIFT = 2;

  localparam int FLD_R = 2;
  localparam int FLD_G = 1;
  localparam int FLD_B = 0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_PRESENT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Field idx of a {R,G,B} word whose channels are ch_bits wide (R in the MSBs).
  function automatic logic [MAX_CH-1:0] px_field(input logic [3*MAX_CH-1:0] word,
                                                 input int unsigned idx,
                                                 input int unsigned ch_bits);
    logic [3*MAX_CH-1:0] mask;
    logic [3*MAX_CH-1:0] fld;
    mask = {(3*MAX_CH){1'b1}} >> (3*MAX_CH - ch_bits);
    fld  = (word >> (idx * ch_bits)) & mask;
    return fld[MAX_CH-1:0];
  endfunction

endpackage

// File: rtl/rgb_to_gray.sv
// Combinational luma approximation, gray = (R + 2G + B) >> 2, truncated to
// CH_BITS; the intermediate sum is two bits wider so it can never overflow.
module rgb_to_gray
  import sobel_pkg::*;
#(
  parameter int CH_BITS = CH_BITS_DEF
) (
  input  logic [CH_BITS-1:0] r,
  input  logic [CH_BITS-1:0] g,
  input  logic [CH_BITS-1:0] b,
  output logic [CH_BITS-1:0] gray
);

  localparam int SW = CH_BITS + 2;
  localparam logic [SW-1:0] WR = SW'(GRAY_WR);
  localparam logic [SW-1:0] WG = SW'(GRAY_WG);
  localparam logic [SW-1:0] WB = SW'(GRAY_WB);

  logic [SW-1:0] sum;

  always_comb begin
    sum  = WR * SW'(r) + WG * SW'(g) + WB * SW'(b);
    gray = CH_BITS'(sum >> GRAY_SHIFT);
  end

endmodule

// File: rtl/pixel_rom_streamer.sv
// Raster-order reader of an external synchronous pixel ROM; presents one pixel
// per valid/ready handshake with coordinates and frame/line markers.
module pixel_rom_streamer
  import sobel_pkg::*;
#(
  parameter int CH_BITS = CH_BITS_DEF,
  parameter int IMG_W   = 32,
  parameter int IMG_H   = 32,
  parameter int ADDR_W  = 10,
  parameter int X_W     = 5,
  parameter int Y_W     = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   mode,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [3*CH_BITS-1:0]   rom_data,
  output logic                   px_valid,
  input  logic                   px_ready,
  output logic [CH_BITS-1:0]     px_r,
  output logic [CH_BITS-1:0]     px_g,
  output logic [CH_BITS-1:0]     px_b,
  output logic [X_W-1:0]         px_x,
  output logic [Y_W-1:0]         px_y,
  output logic                   sof,
  output logic                   eol,
  output logic                   eof
);

  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

  state_t              state;
  logic                mode_q;
  logic [ADDR_W-1:0]   addr;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [CH_BITS-1:0]  r_in, g_in, b_in, gray;

  assign r_in = CH_BITS'(px_field((3*MAX_CH)'(rom_data), FLD_R, CH_BITS));
  assign g_in = CH_BITS'(px_field((3*MAX_CH)'(rom_data), FLD_G, CH_BITS));
  assign b_in = CH_BITS'(px_field((3*MAX_CH)'(rom_data), FLD_B, CH_BITS));

  rgb_to_gray #(.CH_BITS(CH_BITS)) u_gray (
    .r    (r_in),
    .g    (g_in),
    .b    (b_in),
    .gray (gray)
  );

  // rom_addr runs one pixel ahead while a pixel is presented, so the ROM has
  // already read the next word when the handshake lands; it idles at 0 so the
  // first word is read during the start cycle itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      mode_q   <= 1'b0;
      addr     <= '0;
      x        <= '0;
      y        <= '0;
      rom_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      px_valid <= 1'b0;
      px_r     <= '0;
      px_g     <= '0;
      px_b     <= '0;
      px_x     <= '0;
      px_y     <= '0;
      sof      <= 1'b0;
      eol      <= 1'b0;
      eof      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q   <= mode;
            addr     <= '0;
            x        <= '0;
            y        <= '0;
            rom_addr <= '0;
            busy     <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          px_r     <= mode_q ? gray : r_in;
          px_g     <= mode_q ? gray : g_in;
          px_b     <= mode_q ? gray : b_in;
          px_x     <= x;
          px_y     <= y;
          sof      <= (x == '0) && (y == '0);
          eol      <= (x == X_LAST);
          eof      <= (x == X_LAST) && (y == Y_LAST);
          px_valid <= 1'b1;
          rom_addr <= addr + ADDR_W'(1);
          state    <= S_PRESENT;
        end
        S_PRESENT: begin
          if (px_ready) begin
            px_valid <= 1'b0;
            sof      <= 1'b0;
            eol      <= 1'b0;
            eof      <= 1'b0;
            if (eof) begin
              busy     <= 1'b0;
              done     <= 1'b1;
              rom_addr <= '0;
              state    <= S_DONE;
            end else begin
              addr <= addr + ADDR_W'(1);
              if (x == X_LAST) begin
                x <= '0;
                y <= y + Y_W'(1);
              end else begin
                x <= x + X_W'(1);
              end
              state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pixel_rom_streamer.md
Name: pixel_rom_streamer

Overview:
- Parametrised successor to the 4-bit RGB pixel ROM read path.
- Scans an IMG_W x IMG_H image held in an external synchronous pixel ROM in raster order and emits one pixel per valid/ready handshake.
- Per-frame mode selects RGB passthrough or luma-approximated grayscale.
- Sits between the image ROM and the Sobel window/line-buffer stage; supplies x/y coordinates and frame/line markers.

Parameters:
- CH_BITS, 4, bits per colour channel; ROM word is 3*CH_BITS, packed {R,G,B} with R in the MSBs.
- IMG_W, 32, pixels per line.
- IMG_H, 32, lines per frame.
- ADDR_W, 10, ROM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- X_W, 5, x coordinate width; must satisfy 2^X_W >= IMG_W.
- Y_W, 5, y coordinate width; must satisfy 2^Y_W >= IMG_H.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  frame request pulse; sampled only in IDLE.
- mode  in  1  0 = RGB, 1 = gray; latched on accepted start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last pixel handshakes.
- rom_addr  out  ADDR_W  ROM read address; data returns one cycle later.
- rom_data  in  3*CH_BITS  ROM read data, valid the cycle after rom_addr.
- px_valid  out  1  output pixel valid.
- px_ready  in  1  downstream accept.
- px_r, px_g, px_b  out  CH_BITS each  pixel channels.
- px_x  out  X_W  column of the presented pixel.
- px_y  out  Y_W  row of the presented pixel.
- sof  out  1  presented pixel is (0,0).
- eol  out  1  presented pixel is x = IMG_W-1.
- eof  out  1  presented pixel is the last pixel of the frame.

Behaviour:
- Reset (rst=1 at posedge): state IDLE. All outputs 0, including rom_addr, busy, done, px_valid, px_r/g/b, px_x, px_y, sof, eol, eof. Latched mode is 0. Reset mid-frame abandons the frame immediately; no done pulse is produced.
- FSM states: IDLE, FETCH, PRESENT, DONE.
- IDLE:
  - start=1 latches mode, clears x, y and linear address to 0, then goes to FETCH.
  - start=0 stays in IDLE.
- FETCH:
  - rom_addr holds the linear address.
  - Next edge captures rom_data into the output registers, transforms it per mode, and goes to PRESENT.
- PRESENT:
  - px_valid=1. Data, coordinates and markers are held stable while px_ready=0.
  - On px_valid & px_ready with eof=0: advance the pixel and go to FETCH.
  - On px_valid & px_ready with eof=1: go to DONE.
  - px_valid drops in the cycle after the handshake.
- Pixel advance:
  - Linear address +1.
  - If x = IMG_W-1: x wraps to 0 and y increments. Otherwise x increments.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- busy is high in FETCH and PRESENT.
- start during FETCH, PRESENT or DONE is ignored, with no queuing.
- Latency: first px_valid asserts 2 cycles after the start cycle. Maximum throughput is 1 pixel per 2 cycles.
- RGB mode: px_r/g/b are the packed fields of rom_data.
- Gray mode:
  - gray = (R + 2G + B) >> 2, computed in CH_BITS+2 bits and truncated to CH_BITS. No overflow is possible.
  - gray is driven on all three channels.
- Markers:
  - sof = (x==0 && y==0).
  - eol = (x==IMG_W-1).
  - eof = (eol && y==IMG_H-1).
  - Markers are registered alongside the pixel and valid only while px_valid=1; they are 0 otherwise.
- mode changes mid-frame have no effect until the next accepted start.
- A 1x1 image (IMG_W=IMG_H=1): sof, eol and eof are all set on the single pixel.

Decomposition:
- Shared package (sobel_pkg): CH_BITS default, FSM state encoding constants, a pixel-field packing function (extract R/G/B from a 3*CH_BITS word), and the gray weighting constants.
- One natural sub-module: rgb_to_gray, a combinational CH_BITS-parametrised converter. It is reused later by the Sobel front end.
- Everything else is flat in pixel_rom_streamer.

Test Plan:
1. Reset then idle: hold rst 3 cycles, release, start=0 for 10 cycles -> all outputs 0; rom_addr stays 0.
2. RGB frame with px_ready=1, ROM loaded so word = address, ROM[13]=0xAAA:
   - Expect 1024 handshakes in order, with pixel 13 = R=0xA G=0xA B=0xA at x=13 y=0.
   - sof on the first pixel only; eol on every 32nd pixel; eof plus a done pulse after pixel 1023; 2048 cycles from start to done ±2.
3. Gray mode: ROM[0]=0xF0F (R=F G=0 B=F), ROM[1]=0x4C8:
   - Pixel 0 gray = (15+0+15)>>2 = 7 on all channels.
   - Pixel 1 gray = (4+24+8)>>2 = 9.
4. Backpressure: px_ready low for 5 cycles on pixel 31 -> px_valid, data, x=31, y=0 and eol held stable; the next pixel is x=0 y=1 after release.
5. Start ignored and mode latching: pulse start again and toggle mode during a frame -> no restart; addresses continue monotonically; channel format unchanged until the next frame.
6. Reset mid-frame: assert rst at pixel 500 -> next cycle px_valid=0 and busy=0 with no done pulse; a new start streams again from address 0 with sof.
